cdb_arbiter: RTL and testbench

Common-data-bus arbiter and broadcaster that sits directly downstream of the ALU reservation stations. Each station raises a result request with 4-bit result data. The arbiter picks one winner per cycle by round-robin and returns a one-cycle accepted pulse to it. It then drives a registered broadcast (valid, tag, data) that feeds back into every station's CDB input. Each station's tag is derived from its port index, so stations never carry their own tag.

---
 rtl/cdb_arbiter.sv | 104 ++++++++++
 tb/tb_cdb_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Round-robin arbiter and broadcaster for the common data bus. Each
//   reservation station raises req with its result. One winner is chosen
//   per cycle and gets a one-cycle accepted pulse. The same cycle carries a
//   registered broadcast of (valid, tag, data). A station's tag is
//   TAG_BASE + its port index, so stations never carry their own tag.
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   req       : per-station result request
//   req_data  : per-station result, slice i = [i*DATA_W +: DATA_W]
//   bus_busy  : external producer owns the bus this cycle, no grant
//   accepted  : registered one-hot grant pulse to the winning station
//   cdb_valid : registered broadcast valid
//   cdb_tag   : registered broadcast tag
//   cdb_data  : registered broadcast data
module cdb_arbiter #(
  parameter int N_SRC    = 4,
  parameter int DATA_W   = 4,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        req,
  input  logic [N_SRC*DATA_W-1:0] req_data,
  input  logic                    bus_busy,
  output logic [N_SRC-1:0]        accepted,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data
);

  localparam int              PTR_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [PTR_W:0]  N_IDX    = (PTR_W+1)'(N_SRC);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_SRC-1);

  // Broadcast tag of a station, derived from its port index.
  function automatic logic [TAG_W-1:0] src_tag(input logic [PTR_W-1:0] idx);
    return TAG_W'(TAG_BASE) + TAG_W'(idx);
  endfunction

  // Explicit wrap so a non-power-of-two N_SRC never reaches an unused index.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  logic [PTR_W-1:0]  ptr;
  logic [DATA_W-1:0] slice_p0 [N_SRC];
  logic [N_SRC-1:0]  elig_p0;
  logic [N_SRC-1:0]  onehot_p0;
  logic              found_p0;
  logic [PTR_W-1:0]  win_p0;
  logic [PTR_W:0]    idx_ext;
  logic [PTR_W-1:0]  cand;

  for (genvar g = 0; g < N_SRC; g++) begin : g_slice
    assign slice_p0[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Stage p0: eligibility and round-robin scan starting at ptr.
  // A station holding accepted this cycle is masked so the req it still
  // shows on the edge ending its accepted cycle cannot win a second time.
  always_comb begin
    elig_p0   = req & ~accepted & {N_SRC{~bus_busy}};
    found_p0  = 1'b0;
    win_p0    = '0;
    idx_ext   = '0;
    cand      = '0;
    onehot_p0 = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx_ext = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx_ext >= N_IDX) idx_ext = idx_ext - N_IDX;
      cand = idx_ext[PTR_W-1:0];
      if (!found_p0 && elig_p0[cand]) begin
        found_p0 = 1'b1;
        win_p0   = cand;
      end
    end
    if (found_p0) onehot_p0[win_p0] = 1'b1;
  end

  // Stage p1: registered grant and broadcast. Tag and data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepted  <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      ptr       <= '0;
    end else if (found_p0) begin
      accepted  <= onehot_p0;
      cdb_valid <= 1'b1;
      cdb_tag   <= src_tag(win_p0);
      cdb_data  <= slice_p0[win_p0];
      ptr       <= next_ptr(win_p0);
    end else begin
      accepted  <= '0;
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic        bus_busy;
  logic [3:0]  accepted;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [3:0]  cdb_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_ptr;
  logic [3:0] m_acc;
  logic       m_vld;
  logic [3:0] m_tag;
  logic [3:0] m_data;

  cdb_arbiter #(.N_SRC(4), .DATA_W(4), .TAG_W(4), .TAG_BASE(1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .bus_busy(bus_busy),
    .accepted(accepted), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_ptr = 0; m_acc = '0; m_vld = 1'b0; m_tag = '0; m_data = '0;
  endtask

  // Advance one clock; the model picks a winner from the inputs the DUT samples.
  task automatic tick();
    logic [3:0] elig;
    logic [3:0] wdata;
    int win;
    elig  = req & ~m_acc & {4{~bus_busy}};
    win   = -1;
    wdata = '0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (win < 0 && elig[idx]) win = idx;
    end
    if (win >= 0) wdata = req_data[win*4 +: 4];
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else if (win >= 0) begin
      m_vld = 1'b1; m_tag = 4'(1 + win); m_data = wdata;
      m_acc = 4'b0001 << win; m_ptr = (win + 1) % 4;
    end else begin
      m_vld = 1'b0; m_acc = '0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (accepted !== 4'b0000) begin errors++; $display("FAIL reset_acc: got %b want 0000", accepted); end
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", cdb_valid); end
    checks++; if (cdb_tag !== 4'h0) begin errors++; $display("FAIL reset_tag: got %h want 0", cdb_tag); end
    checks++; if (cdb_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h want 0", cdb_data); end
    rst = 1'b0;
    model_reset();
    req = 4'b1111; req_data = 16'h4321;
    tick(); tick();
    // Asynchronous reset in the middle of a broadcast
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (accepted !== 4'b0000) begin errors++; $display("FAIL midrst_acc: got %b want 0000", accepted); end
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL midrst_vld: got %b want 0", cdb_valid); end
    checks++; if (cdb_tag !== 4'h0) begin errors++; $display("FAIL midrst_tag: got %h want 0", cdb_tag); end
    checks++; if (cdb_data !== 4'h0) begin errors++; $display("FAIL midrst_data: got %h want 0", cdb_data); end
    tick();
    req = 4'b1010;
    rst = 1'b0;
    tick();
    checks++; if (accepted !== 4'b0010) begin errors++; $display("FAIL postrst_acc: got %b want 0010", accepted); end
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL postrst_vld: got %b want 1", cdb_valid); end
    checks++; if (cdb_tag !== 4'h2) begin errors++; $display("FAIL postrst_tag: got %h want 2", cdb_tag); end
    checks++; if (cdb_data !== 4'h2) begin errors++; $display("FAIL postrst_data: got %h want 2", cdb_data); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0100; req_data = 16'h0A00;
    tick();
    checks++; if (accepted !== 4'b0100) begin errors++; $display("FAIL single_acc: got %b want 0100", accepted); end
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_vld: got %b want 1", cdb_valid); end
    checks++; if (cdb_tag !== 4'h3) begin errors++; $display("FAIL single_tag: got %h want 3", cdb_tag); end
    checks++; if (cdb_data !== 4'hA) begin errors++; $display("FAIL single_data: got %h want A", cdb_data); end
    req = 4'b0000;
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_idle_vld: got %b want 0", cdb_valid); end
    checks++; if (accepted !== 4'b0000) begin errors++; $display("FAIL single_idle_acc: got %b want 0000", accepted); end
  endtask

  // Runs right after the grant to source 2, so the pointer sits at 3.
  task automatic test_wrap();
    req = 4'b1001; req_data = 16'hC00B;
    tick();
    checks++; if (accepted !== 4'b1000 || cdb_tag !== 4'h4 || cdb_data !== 4'hC)
      begin errors++; $display("FAIL wrap_first: got acc=%b tag=%h data=%h want 1000/4/C", accepted, cdb_tag, cdb_data); end
    req[3] = 1'b0;
    tick();
    checks++; if (accepted !== 4'b0001 || cdb_tag !== 4'h1 || cdb_data !== 4'hB)
      begin errors++; $display("FAIL wrap_second: got acc=%b tag=%h data=%h want 0001/1/B", accepted, cdb_tag, cdb_data); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111; req_data = 16'h8765;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (accepted !== (4'b0001 << i) || cdb_valid !== 1'b1 || cdb_tag !== 4'(i + 1) || cdb_data !== 4'(i + 5))
        begin errors++; $display("FAIL rr_slot%0d: got acc=%b vld=%b tag=%h data=%h want %b/1/%0d/%0d",
          i, accepted, cdb_valid, cdb_tag, cdb_data, 4'b0001 << i, i + 1, i + 5); end
      req[i] = 1'b0;
    end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rr_gap_vld: got %b want 0", cdb_valid); end
    req = 4'b1111;
    tick();
    checks++; if (accepted !== 4'b0001 || cdb_tag !== 4'h1)
      begin errors++; $display("FAIL rr_next_round: got acc=%b tag=%h want 0001/1", accepted, cdb_tag); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_bus_busy();
    req = 4'b0010; req_data = 16'h0090; bus_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (cdb_valid !== 1'b0 || accepted !== 4'b0000)
        begin errors++; $display("FAIL busy_cyc%0d: got vld=%b acc=%b want 0/0000", i, cdb_valid, accepted); end
    end
    bus_busy = 1'b0;
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 4'h2 || cdb_data !== 4'h9)
      begin errors++; $display("FAIL busy_release: got vld=%b tag=%h data=%h want 1/2/9", cdb_valid, cdb_tag, cdb_data); end
    req = 4'b0000;
    tick();
  endtask

  // Pointer is at 2 here, so with req=0011 source 0 wins first.
  task automatic test_masking();
    req = 4'b0011; req_data = 16'h00E7;
    tick();
    checks++; if (accepted !== 4'b0001) begin errors++; $display("FAIL mask_first: got %b want 0001", accepted); end
    tick();
    checks++; if (accepted !== 4'b0010 || cdb_tag !== 4'h2 || cdb_data !== 4'hE)
      begin errors++; $display("FAIL mask_second: got acc=%b tag=%h data=%h want 0010/2/E", accepted, cdb_tag, cdb_data); end
    req = 4'b0000;
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL mask_idle: got %b want 0", cdb_valid); end
  endtask

  task automatic test_random();
    logic [3:0] extra;
    extra = '0;
    for (int c = 0; c < 400; c++) begin
      bus_busy = ($urandom_range(0, 4) == 0);
      tick();
      checks++;
      if (accepted !== m_acc || cdb_valid !== m_vld || (m_vld && (cdb_tag !== m_tag || cdb_data !== m_data)))
        begin errors++; $display("FAIL random_cyc%0d: got acc=%b vld=%b tag=%h data=%h want %b/%b/%h/%h",
          c, accepted, cdb_valid, cdb_tag, cdb_data, m_acc, m_vld, m_tag, m_data); end
      for (int i = 0; i < 4; i++) begin
        if (extra[i]) begin
          req[i] = 1'b0; extra[i] = 1'b0;
        end else if (m_acc[i]) begin
          if ($urandom_range(0, 7) == 0) extra[i] = 1'b1;
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_data[i*4 +: 4] = 4'($urandom);
        end
      end
    end
    req = 4'b0000; bus_busy = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; bus_busy = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_bus_busy();
    test_masking();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
